// File: rtl/demux_collector.sv
// demux_collector
//   Four-lane request collector with round-robin serialisation. Each lane
//   buffers one data bit. Buffered entries are emitted one at a time as a
//   (lane select, data bit) pair on a valid/ready output.
//
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   req    in   [3:0] per-lane request, held until acked
//   din    in   [3:0] per-lane data bit, valid while req is high
//   ack    out  [3:0] per-lane accept (combinational from req and pending)
//   valid  out  output entry present (registered)
//   ready  in   downstream accepts the current output entry
//   sel    out  [1:0] lane index of the current output entry (registered)
//   dout   out  data bit of the current output entry (registered)
//
// state | meaning
// IDLE  | no output entry presented (valid=0)
// HOLD  | output entry presented, waiting for ready (valid=1)

module demux_collector (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic [3:0] din,
    output logic [3:0] ack,
    output logic       valid,
    input  logic       ready,
    output logic [1:0] sel,
    output logic       dout
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t     state;
    state_t     state_nxt;

    logic [3:0] pending;
    logic [3:0] pending_nxt;
    logic [3:0] pdata;
    logic [3:0] pdata_nxt;
    logic [1:0] ptr;
    logic [1:0] ptr_nxt;
    logic [1:0] sel_nxt;
    logic       dout_nxt;

    logic       load;
    logic       found;
    logic [1:0] win;
    logic       grant;
    logic [3:0] grant_mask;

    // A lane already holding an entry is not acked, so buffered data is
    // never overwritten. ready does not reach ack.
    assign ack   = {4{rst_n}} & req & ~pending;

    // valid is the state flop itself.
    assign valid = (state == HOLD);
    assign load  = ~valid | ready;

    // Round-robin pick over registered pending, starting at ptr. Scanning
    // from the farthest offset down lets the nearest pending lane win.
    always_comb begin
        logic [1:0] idx;
        found = 1'b0;
        win   = ptr;
        idx   = ptr;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (pending[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // State register and datapath flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pending <= 4'b0000;
            pdata   <= 4'b0000;
            ptr     <= 2'b00;
            sel     <= 2'b00;
            dout    <= 1'b0;
        end else begin
            state   <= state_nxt;
            pending <= pending_nxt;
            pdata   <= pdata_nxt;
            ptr     <= ptr_nxt;
            sel     <= sel_nxt;
            dout    <= dout_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (found) state_nxt = HOLD;
            HOLD: if (ready) state_nxt = found ? HOLD : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output / datapath update. A grant only happens when the output
    // register is loadable; otherwise everything already presented or
    // buffered stays frozen while empty lanes may still capture.
    always_comb begin
        grant      = load & found;
        grant_mask = 4'b0000;
        if (grant) grant_mask[win] = 1'b1;

        // ack never targets a pending lane, so capture and grant never
        // collide on the same bit.
        pending_nxt = (pending & ~grant_mask) | ack;
        pdata_nxt   = (pdata & ~ack) | (din & ack);

        ptr_nxt  = ptr;
        sel_nxt  = sel;
        dout_nxt = dout;
        if (grant) begin
            ptr_nxt  = win + 2'd1;
            sel_nxt  = win;
            dout_nxt = pdata[win];
        end
    end

endmodule

// File: tb/tb_demux_collector.sv
module tb_demux_collector;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] din;
    logic [3:0] ack;
    logic       valid;
    logic       ready;
    logic [1:0] sel;
    logic       dout;

    int checks   = 0;
    int failures = 0;

    // Expected output entries {sel, dout}, in emission order.
    logic [2:0] exp_q[$];

    // Behavioural reference: one slot per lane plus a rotating start index.
    bit [3:0] m_pend;
    bit [3:0] m_data;
    int       m_ptr;
    bit       m_valid;

    demux_collector dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .din   (din),
        .ack   (ack),
        .valid (valid),
        .ready (ready),
        .sel   (sel),
        .dout  (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: steps at the falling edge, predicting what the next
    // rising edge does with the inputs that are stable around it.
    always @(negedge clk) begin
        bit [3:0] exp_ack;
        bit       found;
        int       w;
        int       lane;
        if (!rst_n) begin
            m_pend  = '0;
            m_data  = '0;
            m_ptr   = 0;
            m_valid = 0;
            check("ack_in_reset", int'(ack), 0);
        end else begin
            exp_ack = req & ~m_pend;
            check("ack", int'(ack), int'(exp_ack));
            check("valid", int'(valid), int'(m_valid));
            if (!m_valid || ready) begin
                found = 0;
                w     = 0;
                for (int k = 0; k < 4; k++) begin
                    lane = (m_ptr + k) % 4;
                    if (!found && m_pend[lane]) begin
                        found = 1;
                        w     = lane;
                    end
                end
                if (found) begin
                    exp_q.push_back({2'(w), m_data[w]});
                    m_pend[w] = 0;
                    m_ptr     = (w + 1) % 4;
                    m_valid   = 1;
                end else begin
                    m_valid = 0;
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (exp_ack[i]) begin
                    m_pend[i] = 1;
                    m_data[i] = din[i];
                end
            end
        end
    end

    // Monitor: every accepted output entry is compared with the oldest
    // expected entry.
    always @(negedge clk) begin
        logic [2:0] e;
        if (rst_n && valid && ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_entry: got sel=%0d dout=%0d with nothing expected at %0t",
                         sel, dout, $time);
            end else begin
                e = exp_q.pop_front();
                check("entry_sel", int'(sel), int'(e[2:1]));
                check("entry_dout", int'(dout), int'(e[0]));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_valid", int'(valid), 0);
        check("rst_sel", int'(sel), 0);
        check("rst_dout", int'(dout), 0);
        check("rst_ack", int'(ack), 0);
        exp_q.delete();
        repeat (cycles) step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 4'b0000;
        din   = 4'b0000;
        ready = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;

        // Full burst: lanes emerge in order 0..3 carrying din=1010.
        step();
        req   = 4'b1111;
        din   = 4'b1010;
        ready = 1'b1;
        step();
        req = 4'b0000;
        din = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            step();
            check("burst_valid", int'(valid), 1);
            check("burst_sel", int'(sel), k);
            check("burst_dout", int'(dout), k % 2);
        end
        step();
        check("burst_end_valid", int'(valid), 0);

        // Backpressure after the first entry of a second burst.
        req = 4'b1111;
        din = 4'b1010;
        step();
        req = 4'b0000;
        din = 4'b0000;
        step();
        ready = 1'b0;
        req   = 4'b0010;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("bp_valid", int'(valid), 1);
            check("bp_sel", int'(sel), 0);
            check("bp_dout", int'(dout), 0);
            check("bp_ack1", int'(ack[1]), 0);
            step();
        end
        ready = 1'b1;
        req   = 4'b0000;
        step();
        check("bp_resume_sel", int'(sel), 1);
        check("bp_resume_dout", int'(dout), 1);
        repeat (6) step();

        // Fairness and same-cycle grant/request: lanes held high.
        req = 4'b0101;
        din = 4'b0100;
        repeat (12) step();
        req = 4'b1000;
        din = 4'b1000;
        repeat (8) step();
        req = 4'b0000;
        repeat (4) step();

        // Randomized traffic with a mid-stream reset.
        for (int c = 0; c < 3000; c++) begin
            req   = 4'($urandom_range(0, 15));
            din   = 4'($urandom_range(0, 15));
            ready = ($urandom_range(0, 3) != 0);
            if (c == 1500) begin
                req = 4'b1111;
                do_reset(2);
            end else begin
                step();
            end
        end

        req   = 4'b0000;
        ready = 1'b1;
        repeat (10) step();
        check("drain_queue_empty", exp_q.size(), 0);
        check("drain_valid", int'(valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/demux_collector.md
# demux_collector

4-lane request collector and round-robin encoder. It is the inverse end of the 1-to-4 decoder/demux path: it accepts single-bit data from up to four lanes, buffers one entry per lane, and emits a serialized stream of (2-bit lane select, data bit) pairs. A downstream `decoder` can redistribute that stream unchanged. Output uses a valid/ready handshake. Arbitration between pending lanes is round-robin.

## Interface

- No parameters. Lane count is fixed at 4 and select width at 2.
- `clk`  input  1  rising-edge clock
- `rst_n`  input  1  asynchronous active-low reset
- `req`  input  4  per-lane request; lane i holds `req[i]` until `ack[i]`
- `din`  input  4  per-lane data bit; `din[i]` is valid while `req[i]` is high
- `ack`  output  4  per-lane accept, combinational; a transfer occurs on the edge where `req[i] & ack[i]`
- `valid`  output  1  output entry present (registered)
- `ready`  input  1  downstream accepts; a transfer occurs on the edge where `valid & ready`
- `sel`  output  2  lane index of the current output entry (registered)
- `dout`  output  1  data bit of the current output entry (registered)

## Operation

Storage:
- `pending[3:0]` holds one flag per lane.
- `pdata[3:0]` holds the buffered data bit per lane.
- `ptr[1:0]` is the round-robin start index.
- Output register set is `valid`, `sel`, `dout`.

Capture:
- `ack[i] = rst_n & req[i] & ~pending[i]`.
- On an edge with `ack[i]`: set `pending[i] <= 1` and `pdata[i] <= din[i]`.
- A lane with `pending[i]=1` is not acked. The requester waits, and no data is overwritten.

Output load:
- The output register loads when `load = ~valid | ready`.
- The winner is the first set bit of the registered `pending`, scanning `ptr`, `ptr+1`, `ptr+2`, `ptr+3` (mod 4).
- A winner w exists: `valid <= 1`, `sel <= w`, `dout <= pdata[w]`, `pending[w] <= 0`, `ptr <= w+1` (mod 4; 3 wraps to 0).
- No winner: `valid <= 0`. `sel`, `dout` and `ptr` hold.
- Requests arriving in the current cycle are not eligible for grant until the next edge; there is no bypass.

Control states:
- IDLE: `valid=0`.
- HOLD: `valid=1`.
- IDLE to HOLD when `pending != 0`.
- HOLD to HOLD on `ready` with `pending != 0` (back-to-back, one entry per cycle).
- HOLD to IDLE on `ready` with `pending == 0`.
- While `valid & ~ready`: `valid`, `sel`, `dout`, `ptr` and all pending bits that are already set are frozen. Empty lanes may still capture.

Simultaneous events:
- Grant of lane w and a new `req[w]` in the same cycle: `ack[w]=0`, because `pending[w]` is still set. The lane is acked on the next cycle. Per-lane throughput is therefore 1 entry per 2 cycles; aggregate throughput is 1 per cycle.
- Capture on lane i and grant of lane j≠i in the same cycle: both take effect.

Reset (asserted asynchronously, also mid-operation):
- `pending=0`, `pdata=0`, `ptr=0`, `valid=0`, `sel=2'b00`, `dout=0`.
- `ack=0` while `rst_n` is low.
- An in-flight output entry and buffered data are discarded.

## Timing

- Capture to output latency:
  - `req[i]` acked at edge N sets `pending[i]` at N.
  - Earliest `valid=1` with `sel=i` is after edge N+1, provided the output register was loadable at N+1 and lane i wins.
- `ack` is combinational from `req` and registered `pending`. There is no combinational path from `ready` to `ack`.
- `valid`, `sel` and `dout` come directly from flops.
- Reset release: the first capture can occur at the first rising edge with `rst_n` high.

## Test plan

- Reset: drive `rst_n=0` mid-stream with `req=4'b1111` and `pending=4'b1010`. Required: immediately `valid=0`, `sel=00`, `dout=0`, `ack=0000`. After release, the first grant is lane 0.
- Single lane: `req=0100`, `din=0100`, `ready=1`, from IDLE. Required: `ack=0100` in cycle 0, then `valid=1`, `sel=10`, `dout=1` in cycle 1, then `valid=0` in cycle 2 once `req` drops.
- Full burst: all four lanes request in the same cycle with `din=1010` and `ready=1`. Required: output sequence (`sel`,`dout`) = (00,0), (01,1), (10,0), (11,1) on consecutive cycles, then `valid=0`; `ptr` wraps to 0.
- Backpressure: from the burst state, drive `ready=0` for 5 cycles after the first entry. Required: `sel=00` and `dout=0` held stable with `valid=1`; a re-asserted `req[1]` sees `ack[1]=0`. On `ready=1` the sequence resumes at `sel=01`.
- Fairness: `req[0]` and `req[2]` held high continuously with `ready=1`. Required: grants alternate 0,2,0,2. No lane receives two consecutive grants while the other is pending.
- Same-cycle grant and request: lane 3 is granted while `req[3]` stays high. Required: `ack[3]=0` in the grant cycle, `ack[3]=1` in the next cycle, and the new data appears in a later output entry with `sel=11`.
